// File: rtl/lenet_sequencer.sv
// LeNet run scheduler: arm, go pulse, busy tracking, result latch, timeout.
// Optional LENET_SEQ_VOTE_EN: 2-deep history vote on result digits.
module lenet_sequencer #(
  parameter int GO_PULSE_LEN  = 4,
  parameter int START_TIMEOUT = 64,
  parameter int RUN_TIMEOUT   = 2_000_000,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             data_ready,
  input  logic             lenet_ready,
  input  logic [3:0]       lenet_digit,
  input  logic             err_clr,
  output logic             lenet_go,
  output logic             buf_lock,
  output logic             busy,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             err_timeout,
  output logic [CNT_W-1:0] infer_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int TA = (GO_PULSE_LEN > START_TIMEOUT) ? GO_PULSE_LEN : START_TIMEOUT;
  localparam int TMAX = (TA > RUN_TIMEOUT) ? TA : RUN_TIMEOUT;
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [TW-1:0] GO_LAST  = TW'(GO_PULSE_LEN - 1);
  localparam logic [TW-1:0] ST_LAST  = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] RUN_LAST = TW'(RUN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_GO,
    S_WAIT,
    S_RUN,
    S_ERR
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic          dr_q;
  logic          dr_edge;
  logic          done;
  logic          to_err;
  logic          drop_st;
  logic [3:0]    digit_sel;

  assign dr_edge  = data_ready & ~dr_q;
  assign lenet_go = (state == S_GO);
  assign busy     = (state == S_GO) || (state == S_WAIT) || (state == S_RUN);
  assign buf_lock = busy;
  assign drop_st  = busy || (state == S_ERR);

  always_comb begin
    state_n = state;
    timer_n = timer + TW'(1);
    done    = 1'b0;
    to_err  = 1'b0;
    unique case (state)
      S_IDLE: begin
        timer_n = '0;
        if (enable) state_n = S_ARM;
      end
      S_ARM: begin
        timer_n = '0;
        // a frame edge in ARM always starts a run
        if (dr_edge) state_n = S_GO;
        else if (!enable) state_n = S_IDLE;
      end
      S_GO: begin
        if (timer == GO_LAST) begin
          state_n = S_WAIT;
          timer_n = '0;
        end
      end
      S_WAIT: begin
        if (!lenet_ready) begin
          state_n = S_RUN;
          timer_n = '0;
        end else if (timer == ST_LAST) begin
          state_n = S_ERR;
          to_err  = 1'b1;
        end
      end
      S_RUN: begin
        if (lenet_ready) begin
          done    = 1'b1;
          state_n = enable ? S_ARM : S_IDLE;
        end else if (timer == RUN_LAST) begin
          state_n = S_ERR;
          to_err  = 1'b1;
        end
      end
      S_ERR: begin
        timer_n = '0;
        if (err_clr) state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
        timer_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      timer       <= '0;
      dr_q        <= 1'b0;
      digit       <= '0;
      digit_valid <= 1'b0;
      err_timeout <= 1'b0;
      infer_cnt   <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      dr_q        <= data_ready;
      digit_valid <= done;
      if (done) begin
        digit     <= digit_sel;
        infer_cnt <= infer_cnt + CNT_W'(1);
      end
      if (to_err) err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
      if (dr_edge && drop_st && (drop_cnt != '1))
        drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

`ifdef LENET_SEQ_VOTE_EN
  logic [3:0] h0, h1;
  logic       v0, v1;

  always_comb begin
    digit_sel = lenet_digit;
    if ((v0 && lenet_digit == h0) || (v1 && lenet_digit == h1))
      digit_sel = lenet_digit;
    else if (v0 && v1 && h0 == h1)
      digit_sel = h0;
  end

  // history keeps raw results, not voted ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h0 <= '0;
      h1 <= '0;
      v0 <= 1'b0;
      v1 <= 1'b0;
    end else if (done) begin
      h1 <= h0;
      h0 <= lenet_digit;
      v1 <= v0;
      v0 <= 1'b1;
    end
  end
`else
  assign digit_sel = lenet_digit;
`endif

endmodule
